// File: rtl/bus_slave_regbank.sv
// Bus-slave register bank: NUM_REGS x 32-bit registers behind a strobe/select
// bus with a fixed wait-state count, per-register read-only mask and per-register
// hardware update ports.
// Optional build macro BUS_SLAVE_REGBANK_ERR_EN: when defined, berror pulses with
// bdone for out-of-range, misaligned or write-to-read-only accesses; otherwise
// berror is tied low.

package bus_if_types_pkg;
    typedef enum logic [1:0] {
        TSIZE_BYTE = 2'd0,
        TSIZE_HALF = 2'd1,
        TSIZE_WORD = 2'd2
    } tsize_e;

    typedef enum logic {
        TTYPE_READ  = 1'b0,
        TTYPE_WRITE = 1'b1
    } ttype_e;
endpackage

module bus_slave_regbank
    import bus_if_types_pkg::*;
#(
    parameter int unsigned           NUM_REGS    = 8,
    parameter logic [31:0]           BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [31:0]           RST_VAL     = 32'h0
) (
    input  logic                     bclk,
    input  logic                     brst,
    input  logic                     bstart,
    input  logic                     ss,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    input  tsize_e                   tsize,
    input  ttype_e                   ttype,
    output logic [31:0]              rdata,
    output logic                     bdone,
    output logic                     berror,
    output logic [NUM_REGS*32-1:0]   regs_o,
    input  logic [NUM_REGS-1:0]      hw_wr_en,
    input  logic [NUM_REGS*32-1:0]   hw_wr_data
);

    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);
    localparam logic [CNT_W-1:0] LAST_WAIT =
        CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
    localparam logic [255:0] RO_EXT = 256'(RO_MASK);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    tsize_e      lat_tsize;
    ttype_e      lat_ttype;

    logic [31:0] regs      [NUM_REGS];
    logic [31:0] regs_next [NUM_REGS];

    logic        accept;
    logic [31:0] eff_addr;
    tsize_e      eff_tsize;
    ttype_e      eff_ttype;
    logic [31:0] offset;
    logic [7:0]  idx;
    logic        in_range;
    logic        misaligned;
    logic        is_write;
    logic        acc_err;
    logic [31:0] rd_word;
    logic [3:0]  lane_mask;
    logic        commit;

    assign accept = bstart && ss && (state == S_IDLE);

    // Address decode: live bus inputs in IDLE, latched transaction afterwards
    always_comb begin
        eff_addr   = lat_addr;
        eff_tsize  = lat_tsize;
        eff_ttype  = lat_ttype;
        rd_word    = 32'h0;
        lane_mask  = 4'hF;
        if (state == S_IDLE) begin
            eff_addr  = addr;
            eff_tsize = tsize;
            eff_ttype = ttype;
        end
        offset     = eff_addr - BASE_ADDR;
        in_range   = (eff_addr >= BASE_ADDR) && (offset < SPAN);
        idx        = offset[9:2];
        misaligned = ((eff_tsize == TSIZE_HALF) && eff_addr[0]) ||
                     ((eff_tsize == TSIZE_WORD) && (eff_addr[1:0] != 2'b00));
        is_write   = (eff_ttype == TTYPE_WRITE);
        acc_err    = !in_range || misaligned || (is_write && RO_EXT[idx]);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 8'(i)) begin
                rd_word = regs[i];
            end
        end
        if (eff_tsize == TSIZE_BYTE) begin
            lane_mask = 4'b0001 << eff_addr[1:0];
        end else if (eff_tsize == TSIZE_HALF) begin
            lane_mask = eff_addr[1] ? 4'b1100 : 4'b0011;
        end
        commit = (state == S_RESP) && is_write && !acc_err;
    end

    // Next-state and wait counter
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    wait_cnt_next = '0;
                    state_next    = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt == LAST_WAIT) begin
                    state_next = S_RESP;
                end else begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge bclk) begin
        if (brst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Capture the transaction on accept; bus is ignored until back in IDLE
    always_ff @(posedge bclk) begin
        if (brst) begin
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_tsize <= TSIZE_BYTE;
            lat_ttype <= TTYPE_READ;
        end else if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_tsize <= tsize;
            lat_ttype <= ttype;
        end
    end

    // Response outputs, loaded on entry to RESP so they are visible during it
    always_ff @(posedge bclk) begin
        if (brst) begin
            bdone <= 1'b0;
            rdata <= 32'h0;
        end else begin
            bdone <= (state_next == S_RESP);
            rdata <= ((state_next == S_RESP) && !is_write && !acc_err) ? rd_word : 32'h0;
        end
    end

`ifdef BUS_SLAVE_REGBANK_ERR_EN
    // Error flag travels with bdone
    always_ff @(posedge bclk) begin
        if (brst) begin
            berror <= 1'b0;
        end else begin
            berror <= (state_next == S_RESP) && acc_err;
        end
    end
`else
    assign berror = 1'b0;
`endif

    // Register next value: hardware load first, bus write lanes override it
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_next[i] = hw_wr_en[i] ? hw_wr_data[32*i +: 32] : regs[i];
            if (commit && (idx == 8'(i))) begin
                for (int b = 0; b < 4; b++) begin
                    if (lane_mask[b]) begin
                        regs_next[i][8*b +: 8] = lat_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Register storage
    always_ff @(posedge bclk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (brst) begin
                regs[i] <= RST_VAL;
            end else begin
                regs[i] <= regs_next[i];
            end
        end
    end

    // Flatten register contents
    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_o[32*i +: 32] = regs[i];
        end
    end

endmodule

// File: doc/bus_slave_regbank.md
BUS_SLAVE_REGBANK -- requirements
Module: bus_slave_regbank

Interface
REQ-001 Parameter NUM_REGS, default 8: number of 32-bit registers; legal range 1..256.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of register 0; 4-byte aligned.
REQ-003 Parameter WAIT_STATES, default 0: extra cycles inserted before the response; legal range 0..15.
REQ-004 Parameter RO_MASK, default all zeros, NUM_REGS bits: bit i set means register i is read-only from the bus.
REQ-005 Parameter RST_VAL, default 32'h0: reset value of every register.
REQ-006 Reset is synchronous and active-high; single clock bclk.
REQ-007 bclk  in  1  bus clock; all logic on the rising edge.
REQ-008 brst  in  1  synchronous active-high reset.
REQ-009 bstart  in  1  one-cycle transaction start strobe.
REQ-010 ss  in  1  slave select; a transaction is accepted only when bstart and ss are both high.
REQ-011 addr  in  32  byte address.
REQ-012 wdata  in  32  write data, lane-aligned to addr[1:0].
REQ-013 tsize  in  tsize_e  byte, halfword or word (bus_if_types_pkg).
REQ-014 ttype  in  ttype_e  read or write (bus_if_types_pkg).
REQ-015 rdata  out  32  read data; valid only while bdone is high, 0 otherwise.
REQ-016 bdone  out  1  one-cycle completion pulse.
REQ-017 berror  out  1  error flag; high only together with bdone.
REQ-018 regs_o  out  NUM_REGS*32  current register contents; register i at bits [32*i+31:32*i].
REQ-019 hw_wr_en  in  NUM_REGS  per-register hardware update strobe.
REQ-020 hw_wr_data  in  NUM_REGS*32  hardware update data, packed like regs_o.

Function
REQ-021 FSM states IDLE, WAIT, RESP: IDLE->WAIT on accept if WAIT_STATES>0, else IDLE->RESP; WAIT->RESP after WAIT_STATES cycles; RESP->IDLE unconditionally.
REQ-022 On accept, addr, wdata, tsize and ttype are latched; bus inputs are not sampled again until IDLE.
REQ-023 bdone is high for exactly one cycle, WAIT_STATES+1 cycles after the accept cycle.
REQ-024 A bstart received in WAIT or RESP is ignored and produces no response.
REQ-025 Decode: offset = addr - BASE_ADDR; the access is in range when addr >= BASE_ADDR and offset < NUM_REGS*4; the register index is offset[9:2].
REQ-026 Misalignment: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-027 Write commits in the RESP cycle. Byte access updates lane addr[1:0] only; halfword access updates lanes addr[1]*2 and addr[1]*2+1 only; other lanes are unchanged.
REQ-028 Read returns the full 32-bit register word regardless of tsize.
REQ-029 Out-of-range, misaligned, or write-to-RO accesses modify no register and return rdata=0.
REQ-030 A hw_wr_en[i] pulse loads register i from hw_wr_data in any state, including RO registers.
REQ-031 When a bus write and hw_wr_en target the same register in the same cycle, the bus write wins for the lanes it writes; hardware data fills the other lanes.
REQ-032 regs_o reflects updates one cycle after the commit edge.

Reset
REQ-033 While brst is high: FSM goes to IDLE, wait counter is 0, bdone=0, berror=0, rdata=0, every register is RST_VAL.
REQ-034 Reset asserted mid-transaction aborts it: no write commits and no bdone is produced.

Configuration
REQ-035 Macro BUS_SLAVE_REGBANK_ERR_EN is defined: berror pulses with bdone for out-of-range, misaligned, or write-to-RO accesses.
REQ-036 Macro BUS_SLAVE_REGBANK_ERR_EN is undefined: berror is tied to 0. Those accesses still complete with bdone, still cause no write, and still return rdata=0.

Verification
REQ-037 WAIT_STATES=0: word write 32'hDEAD_BEEF to BASE_ADDR+4, then a read -> bdone 1 cycle after each accept; rdata=32'hDEAD_BEEF; regs_o[63:32]=32'hDEAD_BEEF.
REQ-038 Register 2 = 32'h1122_3344, byte write 8'hAA to BASE_ADDR+9 -> register 2 = 32'h1122_AA44.
REQ-039 WAIT_STATES=3: read issued, with a second bstart 1 cycle later -> a single bdone 4 cycles after the first accept; second bstart ignored.
REQ-040 With ERR_EN: word read at BASE_ADDR+NUM_REGS*4, and halfword write at BASE_ADDR+1 -> berror=1, bdone=1, rdata=0, registers unchanged; without ERR_EN -> berror=0, same otherwise.
REQ-041 RO_MASK bit0 set: bus write to register 0 plus a same-cycle hw_wr_en[0] with 32'h5 -> register 0 = 32'h5; brst asserted during WAIT -> no bdone, all registers = RST_VAL.
